// File: rtl/gf2_rref_pkg.sv
// rtl/gf2_rref_pkg.sv - shared types for the gf2_rref request scheduler
// Holds the scheduler state encoding and the busy-cycle counter width.
package gf2_rref_pkg;

  localparam int CYC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_state_t;

  // Counter stops at all-ones so long solves never appear short.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gf2_rref_sched.sv
// rtl/gf2_rref_sched.sv - round-robin scheduler sharing one gf2_rref engine
// Grants one requester at a time, drives the engine and returns its RREF result.
module gf2_rref_sched
  import gf2_rref_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ROWS = 3,
  parameter int COLS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*ROWS*COLS-1:0]     req_aug,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [ROWS*COLS-1:0]          rsp_rref,
  output logic [CYC_W-1:0]              rsp_cycles,
  input  logic                          rsp_ready,
  output logic                          eng_start,
  output logic [ROWS*COLS-1:0]          eng_aug,
  input  logic                          eng_ready,
  input  logic [ROWS*COLS-1:0]          eng_rref
);

  localparam int IDW = $clog2(NREQ);
  localparam int MW  = ROWS * COLS;

  sched_state_t   r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [MW-1:0]  r_aug;
  logic           r_first;

  logic [MW-1:0]  w_req_mat [NREQ];
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_gnt_id;
  logic           w_gnt_any;
  logic           w_take;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_req_mat[i] = req_aug[i*MW +: MW];
    end
  end

  // Scan downward so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      if (req_valid[w_sum[IDW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_sum[IDW-1:0];
      end
    end
  end

  assign w_take = !rst && (r_state == ST_IDLE) && eng_ready && w_gnt_any;

  always_comb begin
    req_ready = '0;
    if (w_take) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  assign eng_aug = r_aug;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_aug      <= '0;
      r_first    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rref   <= '0;
      rsp_cycles <= '0;
      eng_start  <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_aug     <= w_req_mat[w_gnt_id];
            rsp_id    <= w_gnt_id;
            eng_start <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_cycles <= '0;
          r_first    <= 1'b1;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // eng_ready is still stale from the previous solve in the first cycle.
          rsp_cycles <= sat_inc(rsp_cycles);
          r_first    <= 1'b0;
          if (!r_first && eng_ready) begin
            rsp_rref  <= eng_rref;
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_rr_ptr  <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_rref_sched.sv
// tb/tb_gf2_rref_sched.sv - randomized self-checking bench for gf2_rref_sched
// A behavioural stub engine with programmable latency stands in for gf2_rref.
module tb_gf2_rref_sched;
  import gf2_rref_pkg::*;

  localparam int NREQ = 4;
  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int MW   = ROWS * COLS;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*MW-1:0]   req_aug;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [MW-1:0]        rsp_rref;
  logic [CYC_W-1:0]     rsp_cycles;
  logic                 rsp_ready = 1'b0;
  logic                 eng_start;
  logic [MW-1:0]        eng_aug;
  logic                 eng_ready = 1'b1;
  logic [MW-1:0]        eng_rref = '0;

  logic [MW-1:0] mats [NREQ];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int eng_lat = 4;
  int e_rem = 0;
  int m_rr_ptr = 0;
  bit e_busy = 1'b0;
  logic [MW-1:0] e_res = '0;

  gf2_rref_sched #(.NREQ(NREQ), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_aug(req_aug), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rref(rsp_rref), .rsp_cycles(rsp_cycles),
    .rsp_ready(rsp_ready), .eng_start(eng_start), .eng_aug(eng_aug), .eng_ready(eng_ready),
    .eng_rref(eng_rref)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (eng_start) n_starts <= n_starts + 1;

  always_comb begin
    req_aug = '0;
    for (int i = 0; i < NREQ; i++) req_aug[i*MW +: MW] = mats[i];
  end

  // Gauss-Jordan over GF(2) on the coefficient columns; bit r*COLS+c is row r, column c.
  function automatic logic [MW-1:0] rref_model(input logic [MW-1:0] a);
    bit m [ROWS][COLS];
    bit t;
    int pr;
    int p;
    logic [MW-1:0] res;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = a[r*COLS + c];
    pr = 0;
    for (int c = 0; c < COLS - 1; c++) begin
      if (pr < ROWS) begin
        p = -1;
        for (int r = ROWS - 1; r >= pr; r--) if (m[r][c]) p = r;
        if (p >= 0) begin
          for (int j = 0; j < COLS; j++) begin
            t = m[p][j]; m[p][j] = m[pr][j]; m[pr][j] = t;
          end
          for (int r = 0; r < ROWS; r++)
            if (r != pr && m[r][c])
              for (int j = 0; j < COLS; j++) m[r][j] = m[r][j] ^ m[pr][j];
          pr++;
        end
      end
    end
    res = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) res[r*COLS + c] = m[r][c];
    return res;
  endfunction

  // Stub engine: ready drops after start, rises eng_lat cycles after it; garbage while busy.
  always @(posedge clk) begin
    if (eng_start) begin
      eng_ready <= 1'b0;
      e_busy    <= 1'b1;
      e_rem     <= eng_lat - 1;
      e_res     <= rref_model(eng_aug);
      eng_rref  <= MW'($urandom);
    end else if (e_busy) begin
      if (e_rem <= 1) begin
        eng_ready <= 1'b1;
        eng_rref  <= e_res;
        e_busy    <= 1'b0;
      end else begin
        e_rem <= e_rem - 1;
      end
    end
  end

  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_solve(input logic [NREQ-1:0] vmask, input int lat, input int hold,
                          input int gbound, output int got_id);
    int exp_id;
    int t_acc;
    int waited;
    int starts0;
    int exp_cyc;
    bit stray;
    logic [MW-1:0] exp_mat;
    logic [MW-1:0] exp_rref;
    got_id  = -1;
    eng_lat = lat;
    req_valid = vmask;
    #1;
    exp_id = model_pick(vmask, m_rr_ptr);
    waited = 0;
    while (req_ready == '0 && waited < gbound) begin
      @(negedge clk); #1; waited++;
    end
    chk("grant_wait", waited < gbound, 1);
    if (waited >= gbound) return;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) got_id = i;
    chk("grant_onehot", req_ready, 64'(1) << exp_id);
    chk("grant_eng_ready", eng_ready, 1);
    exp_mat  = mats[exp_id];
    exp_rref = rref_model(exp_mat);
    exp_cyc  = (lat > 65535) ? 65535 : lat;
    t_acc    = cyc;
    starts0  = n_starts;
    @(negedge clk); #1;
    mats[exp_id] = MW'($urandom);
    chk("issue_start", eng_start, 1);
    chk("issue_aug", eng_aug, exp_mat);
    stray  = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < lat + 20) begin
      req_valid = NREQ'($urandom);
      @(negedge clk); #1; waited++;
      if (req_ready != '0) stray = 1'b1;
    end
    req_valid = vmask;
    chk("rsp_wait", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("latency", cyc - t_acc, lat + 2);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_rref", rsp_rref, exp_rref);
    chk("rsp_cycles", rsp_cycles, exp_cyc);
    chk("one_start", n_starts - starts0, 1);
    chk("no_grant_busy", stray, 0);
    chk("aug_stable", eng_aug, exp_mat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold", {rsp_valid, rsp_id, rsp_rref, rsp_cycles, req_ready, eng_start},
          {1'b1, IDW'(exp_id), exp_rref, CYC_W'(exp_cyc), NREQ'(0), 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    m_rr_ptr = (exp_id + 1) % NREQ;
  endtask

  int gid;
  int waited;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NREQ; i++) mats[i] = MW'($urandom);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_rref", rsp_rref, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_eng_aug", eng_aug, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_solve(4'b1111, 3 + i, 0, 20, gid);
      chk("rr_order", gid, order[i]);
    end

    do_solve(4'b0100, 4, 0, 20, gid);
    chk("solo_id", gid, 2);
    do_solve(NREQ'($urandom_range(1, 15)), 5, 0, 20, gid);
    do_solve(NREQ'($urandom_range(1, 15)), 3, 5, 20, gid);

    for (int n = 0; n < 20; n++)
      do_solve(NREQ'($urandom_range(1, 15)), $urandom_range(2, 12), $urandom_range(0, 3), 20, gid);

    eng_lat = 40;
    req_valid = 4'b1111;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    chk("abort_grant_wait", waited < 50, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_outputs", {req_ready, rsp_valid, rsp_id, rsp_rref, rsp_cycles, eng_start, eng_aug}, 0);
    rst = 1'b0;
    m_rr_ptr = 0;
    #1;
    chk("abort_no_grant_busy", req_ready, 0);
    do_solve(4'b1111, 6, 1, 80, gid);
    chk("abort_regrant_id", gid, 0);

    do_solve(4'b0010, 66000, 0, 20, gid);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gf2_rref_sched.md
GF2_RREF_SCHED -- requirements
Module: gf2_rref_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one gf2_rref engine (2..16).
REQ-002 SHALL have parameter ROWS, default 3, augmented-matrix rows.
REQ-003 SHALL have parameter COLS, default 4, augmented-matrix columns (coefficients plus RHS).
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester solve request.
REQ-008 SHALL have port req_aug  in  NREQ x ROWS x COLS  per-requester augmented matrix, packed.
REQ-009 SHALL have port req_ready  out  NREQ  one-hot accept; request i is taken when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port rsp_valid  out  1  result available.
REQ-011 SHALL have port rsp_id  out  $clog2(NREQ)  index of the requester owning the result.
REQ-012 SHALL have port rsp_rref  out  ROWS x COLS  reduced matrix.
REQ-013 SHALL have port rsp_cycles  out  16  engine busy cycles for this solve, saturating.
REQ-014 SHALL have port rsp_ready  in  1  consumer accepts the result.
REQ-015 SHALL have port eng_start  out  1  single-cycle start pulse to gf2_rref.
REQ-016 SHALL have port eng_aug  out  ROWS x COLS  matrix driven to gf2_rref AUG.
REQ-017 SHALL have port eng_ready  in  1  gf2_rref ready.
REQ-018 SHALL have port eng_rref  in  ROWS x COLS  gf2_rref RREF output.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 Engine contract: eng_ready falls the cycle after eng_start, rises when RREF is valid, and holds RREF until the next start.
REQ-021 In IDLE, when eng_ready=1 and any req_valid is set, SHALL grant the first set requester at or after rr_ptr (wrapping), assert req_ready for that requester only in that cycle, latch its matrix and id, and go to ISSUE.
REQ-022 In IDLE, when eng_ready=0, SHALL keep req_ready all zero and stay in IDLE.
REQ-023 In ISSUE, SHALL pulse eng_start for exactly one cycle with eng_aug equal to the latched matrix, clear the cycle counter, and go to WAIT.
REQ-024 In WAIT, SHALL ignore eng_ready in the first WAIT cycle.
REQ-025 From the second WAIT cycle, on eng_ready=1, SHALL latch eng_rref into rsp_rref and go to RESP.
REQ-026 The cycle counter SHALL increment each WAIT cycle and saturate at 16'hFFFF without wrapping.
REQ-027 In RESP, SHALL hold rsp_valid=1 with stable rsp_id, rsp_rref and rsp_cycles until rsp_ready=1.
REQ-028 On RESP acceptance, SHALL set rr_ptr to (granted id + 1) mod NREQ and return to IDLE.
REQ-029 Back-to-back latency: with L cycles from eng_start to eng_ready high, rsp_valid SHALL rise L+2 cycles after the accept cycle.
REQ-030 SHALL keep at most one solve outstanding.
REQ-031 SHALL ignore req_valid changes outside IDLE.
REQ-032 eng_aug SHALL be stable from ISSUE until the next accept.

Reset
REQ-033 On rst, SHALL set state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, eng_start=0, rsp_id=0, rsp_rref=0, rsp_cycles=0, and the latched matrix to 0.
REQ-034 Reset asserted mid-solve SHALL abandon the solve with no response; the next grant SHALL wait until eng_ready=1.

Structure
REQ-035 SHALL place the FSM state enum and the cycle-counter width constant (16) in shared package gf2_rref_pkg.
REQ-036 SHALL contain no sub-module; the gf2_rref engine SHALL be instantiated beside it by the parent, with the parent driving the engine's rst_n as ~rst.

Verification
REQ-037 NREQ=4, ROWS=2, COLS=3, real gf2_rref: requester 2 alone -> req_ready=4'b0100 for one cycle, one eng_start pulse, then rsp_id=2 and rsp_rref equal to the engine's RREF.
REQ-038 All four req_valid high, rsp_ready tied 1 -> grant order 0,1,2,3,0, and each rsp_id matches its grant.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_id and rsp_rref stable, no new req_ready, eng_start stays 0.
REQ-040 Stub engine holding eng_ready low for 70000 cycles -> rsp_cycles=16'hFFFF.
REQ-041 rst pulsed in WAIT while the engine is busy -> all outputs at reset values; after eng_ready=1 the pending request is granted from rr_ptr=0.
REQ-042 Stub engine with L=5 -> rsp_valid rises exactly 7 cycles after the accept cycle, and rsp_cycles=5.
